// File: rtl/seg_pkg.sv
// seg_pkg: constants and types shared by the seven-segment scanner block
package seg_pkg;
   localparam int DIGITS_MAX = 8;
   localparam logic [DIGITS_MAX-1:0] DIGIT_OFF = '1;
   typedef logic [$clog2(DIGITS_MAX)-1:0] nib_sel_t;
endpackage

// File: rtl/seg_refresh_tick.sv
// seg_refresh_tick: prescaler that pulses tick once every REFRESH_DIV clk cycles
module seg_refresh_tick #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic clk,
   input  logic clr,
   output logic tick
);
   localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
   logic [CW-1:0] cnt;
   assign tick = cnt == CW'(REFRESH_DIV - 1);
   always_ff @(posedge clk)
      if (clr || tick) cnt <= '0;
      else cnt <= cnt + 1'b1;
endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexes a hex value across DIGITS active-low digit enables
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seven_seg_scanner
   import seg_pkg::*;
#(
   parameter int DIGITS      = 8,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                load,
   input  logic [4*DIGITS-1:0] data_in,
   output logic [3:0]          nibble_out,
   output logic [DIGITS-1:0]   digit_en_n,
   output logic                blank,
   output logic                frame_done
);
   logic tick, wrap, blank_now;
   nib_sel_t idx;
   logic [4*DIGITS-1:0] pending, active, sel;

   seg_refresh_tick #(.REFRESH_DIV(REFRESH_DIV)) u_tick (.clk(clk), .clr(clr), .tick(tick));

   assign wrap = tick && idx == nib_sel_t'(DIGITS - 1);
   assign sel  = active >> {idx, 2'b00};

   // active only changes at the frame boundary so a scan never mixes two values
   always_ff @(posedge clk)
      if (clr) begin
         idx     <= '0;
         pending <= '0;
         active  <= '0;
      end else begin
         if (tick) idx <= wrap ? '0 : idx + 1'b1;
         if (load) pending <= data_in;
         if (wrap) active <= pending;
      end

   always_ff @(posedge clk)
      if (clr) begin
         nibble_out <= '0;
         digit_en_n <= DIGIT_OFF[DIGITS-1:0];
         frame_done <= 1'b0;
      end else begin
         nibble_out <= sel[3:0];
         digit_en_n <= blank_now ? DIGIT_OFF[DIGITS-1:0] : ~(DIGITS'(1) << idx);
         frame_done <= wrap;
      end

`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic [DIGITS_MAX-1:0] lz;
   // lz[k]: every nibble from k upward is zero; digit 0 is always lit
   for (genvar k = 0; k < DIGITS_MAX; k++) begin : g_lz
      if (k > 0 && k < DIGITS) begin : g_on
         assign lz[k] = active[4*DIGITS-1:4*k] == '0;
      end else begin : g_off
         assign lz[k] = 1'b0;
      end
   end
   assign blank_now = lz[idx];
   always_ff @(posedge clk)
      blank <= clr ? 1'b0 : blank_now;
`else
   assign blank_now = 1'b0;
   assign blank     = 1'b0;
`endif
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: scoreboard bench; driver queues expected outputs, monitor checks each cycle
module tb_seven_seg_scanner;
   localparam int DIGITS = 8;
   localparam int DIV    = 4;
   localparam int FRAME  = DIV * DIGITS;

   typedef struct packed {
      logic [3:0]        nib;
      logic [DIGITS-1:0] en;
      logic              blank;
      logic              fd;
   } obs_t;

   logic clk = 1'b0, clr = 1'b1, load = 1'b0;
   logic [4*DIGITS-1:0] data_in = '0;
   logic [3:0] nibble_out;
   logic [DIGITS-1:0] digit_en_n;
   logic blank, frame_done;

   obs_t q[$];
   int total = 0, bad = 0, n = 0;
   logic [31:0] pend = '0, shown = '0;

   always #5 clk = ~clk;

   seven_seg_scanner #(.DIGITS(DIGITS), .REFRESH_DIV(DIV)) dut (
      .clk(clk), .clr(clr), .load(load), .data_in(data_in),
      .nibble_out(nibble_out), .digit_en_n(digit_en_n),
      .blank(blank), .frame_done(frame_done)
   );

   // n counts edges since clr released; output after edge n shows digit (n-1)/DIV,
   // and the value loaded into pending before edge FRAME*f is shown after it
   task automatic step(input logic c, input logic l, input logic [31:0] d);
      obs_t e;
      int dg;
      @(negedge clk);
      clr = c;
      load = l;
      data_in = d;
      e = '0;
      if (c) begin
         e.en = '1;
         n = 0;
         pend = '0;
         shown = '0;
      end else begin
         n++;
         dg = ((n - 1) / DIV) % DIGITS;
         e.nib = 4'(shown >> (4 * dg));
`ifdef SEG_LEADING_ZERO_BLANK_EN
         e.blank = dg > 0 && (shown >> (4 * dg)) == 0;
`endif
         e.en = e.blank ? '1 : ~(8'd1 << dg);
         e.fd = n % FRAME == 0;
         if (e.fd) shown = pend;
         if (l) pend = d;
      end
      q.push_back(e);
   endtask

   task automatic idle_to(input int m);
      while (n < m) step(1'b0, 1'b0, 32'h0);
   endtask

   task automatic load_at(input int m, input logic [31:0] v);
      idle_to(m - 1);
      step(1'b0, 1'b1, v);
   endtask

   always @(posedge clk) begin
      obs_t e, a;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         a = {nibble_out, digit_en_n, blank, frame_done};
         total++;
         if (a !== e) begin
            bad++;
            $display("FAIL outputs n=%0d got nib=%h en_n=%h blank=%b fd=%b want nib=%h en_n=%h blank=%b fd=%b",
                     n, a.nib, a.en, a.blank, a.fd, e.nib, e.en, e.blank, e.fd);
         end
      end
   end

   initial begin
      repeat (3) step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'hFFFF_FFFF);
      idle_to(64);
      load_at(70, 32'h1234_ABCD);
      load_at(150, 32'h1111_1111);
      load_at(155, 32'h2222_2222);
      load_at(224, 32'h5555_5555);
      idle_to(309);
      step(1'b1, 1'b1, 32'h9999_9999);
      idle_to(40);
      load_at(20, 32'h0000_0A05);
      idle_to(100);
      load_at(110, 32'h0000_0000);
      idle_to(170);
      @(negedge clk);
      @(negedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain got %0d pending want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
